// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM states, parity modes and defaults.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit buffer for uart_tx: power-of-two ring buffer with a count register
// that determines full/empty, so pointers can simply wrap.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == DEPTH_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only the bookkeeping below is cleared.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes are framed as start, LSB-first data, optional
// parity and stop bits, advancing one bit per baud_tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int PARITY     = PAR_NONE,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [CW-1:0]        bit_cnt;
    logic [CW-1:0]        bit_cnt_nxt;
    logic                 stop_cnt;
    logic                 stop_cnt_nxt;
    logic                 par_bit;
    logic                 par_nxt;
    logic                 tx_nxt;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_data;

    assign in_ready = !fifo_full;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid && in_ready),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx       <= tx_nxt;
            busy     <= (state != ST_IDLE) || !fifo_empty;
            shift    <= shift_nxt;
            bit_cnt  <= bit_cnt_nxt;
            stop_cnt <= stop_cnt_nxt;
            par_bit  <= par_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_nxt       = tx;
        shift_nxt    = shift;
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        par_nxt      = par_bit;
        fifo_pop     = 1'b0;

        if (baud_tick) begin
            case (state)
                ST_IDLE: begin
                    fifo_pop = !fifo_empty;
                end
                ST_START: begin
                    tx_nxt      = shift[0];
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_DATA;
                end
                ST_DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_nxt = 1'b0;
                        if (PARITY != PAR_NONE) begin
                            tx_nxt    = par_bit;
                            state_nxt = ST_PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        shift_nxt   = shift >> 1;
                        tx_nxt      = shift[1];
                        bit_cnt_nxt = bit_cnt + CW'(1);
                    end
                end
                ST_PARITY: begin
                    tx_nxt       = 1'b1;
                    stop_cnt_nxt = 1'b0;
                    state_nxt    = ST_STOP;
                end
                ST_STOP: begin
                    if (stop_cnt == LAST_STOP) begin
                        fifo_pop  = !fifo_empty;
                        state_nxt = ST_IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
                default: begin
                    tx_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            endcase
        end

        // A pop always launches the next frame, whether from IDLE or straight out of STOP.
        if (fifo_pop) begin
            shift_nxt = fifo_data;
            par_nxt   = (^fifo_data) ^ (PARITY == PAR_ODD);
            tx_nxt    = 1'b0;
            state_nxt = ST_START;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a table of single frames checked bit-by-bit, plus hand-written
// back-to-back, overflow, push/pop, continuous-tick and mid-frame reset sequences.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0]  data;
        int          sel;
        int          nbits;
        logic [10:0] bits;
        bit          chk_busy;
    } frame_vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] in_data;
    logic       in_valid;
    logic [2:0] rdy;
    logic [2:0] txl;
    logic [2:0] bsy;

    int n_cmp = 0;
    int n_bad = 0;
    int baud_mode = 0;
    int phase = 0;

    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         stop_err = 0;
    int         idle_ticks = 0;

    frame_vec_t vecs [8];

    always #5 clk = ~clk;

    uart_tx #(.DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .in_data(in_data),
        .in_valid(in_valid), .in_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2]));

    // Serial receiver on the no-parity line: takes one bit per baud tick.
    initial begin : monitor
        bit         in_frame;
        bit         tick;
        int         nbits;
        logic [7:0] sh;
        in_frame = 0;
        nbits    = 0;
        sh       = '0;
        forever begin
            @(posedge clk);
            tick = baud_tick;
            @(negedge clk);
            if (rst) begin
                in_frame   = 0;
                idle_ticks = 0;
            end else if (tick) begin
                if (!in_frame) begin
                    if (txl[0] == 1'b0) begin
                        in_frame = 1;
                        nbits    = 0;
                        gap_q.push_back(idle_ticks);
                        idle_ticks = 0;
                    end else begin
                        idle_ticks++;
                    end
                end else if (nbits < 8) begin
                    sh = {txl[0], sh[7:1]};
                    nbits++;
                end else begin
                    in_frame = 0;
                    if (txl[0] !== 1'b1) stop_err++;
                    rx_q.push_back(sh);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        case (baud_mode)
            1: begin
                phase     = (phase + 1) % 4;
                baud_tick = (phase == 0);
            end
            2:       baud_tick = 1'b1;
            default: baud_tick = 1'b0;
        endcase
    endtask

    task automatic applyStimulus(input logic [7:0] data);
        in_data  = data;
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bsy !== 3'b000 && k < 500) begin
            cycle();
            k++;
        end
        checkOutput("idle reached", bsy, 3'b000);
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k = 0;
        while (rx_q.size() < n && k < limit) begin
            cycle();
            k++;
        end
        checkOutput("frames received", rx_q.size(), n);
    endtask

    // Every bit must hold its value for exactly the four cycles of one baud period.
    task automatic expect_frame(input string tag, input int sel, input logic [10:0] bits, input int nbits);
        int   k = 0;
        logic seen;
        while (txl[sel] !== 1'b0 && k < 200) begin
            cycle();
            k++;
        end
        checkOutput({tag, " start"}, txl[sel], 0);
        if (txl[sel] !== 1'b0) return;
        for (int b = 0; b < nbits; b++) begin
            seen = bits[b];
            for (int s = 0; s < 4; s++) begin
                if (!(b == 0 && s == 0)) cycle();
                if (txl[sel] !== bits[b]) seen = txl[sel];
            end
            checkOutput($sformatf("%s bit%0d", tag, b), seen, bits[b]);
        end
    endtask

    initial begin
        logic tx_min;
        int   k;
        int   maxc;
        bit   accepted;

        vecs[0] = '{8'hA5, 0, 10, {1'b0, 1'b1, 8'hA5, 1'b0}, 1'b1};
        vecs[1] = '{8'h07, 1, 11, {1'b1, 1'b1, 8'h07, 1'b0}, 1'b0};
        vecs[2] = '{8'h07, 2, 11, {1'b1, 1'b0, 8'h07, 1'b0}, 1'b0};
        vecs[3] = '{8'h80, 1, 11, {1'b1, 1'b1, 8'h80, 1'b0}, 1'b0};
        vecs[4] = '{8'h00, 2, 11, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0};
        vecs[5] = '{8'hFF, 1, 11, {1'b1, 1'b0, 8'hFF, 1'b0}, 1'b0};
        vecs[6] = '{8'h3C, 2, 11, {1'b1, 1'b1, 8'h3C, 1'b0}, 1'b0};
        vecs[7] = '{8'h01, 0, 10, {1'b0, 1'b1, 8'h01, 1'b0}, 1'b1};

        rst       = 1'b1;
        baud_tick = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) cycle();
        checkOutput("reset tx", txl, 3'b111);
        checkOutput("reset busy", bsy, 3'b000);
        checkOutput("reset in_ready", rdy, 3'b111);
        checkOutput("reset count", dut0.u_fifo.count, 0);
        rst       = 1'b0;
        baud_mode = 1;
        repeat (8) cycle();
        checkOutput("idle ticks keep tx high", txl, 3'b111);

        for (int i = 0; i < 8; i++) begin
            wait_idle();
            checkOutput($sformatf("v%0d in_ready", i), rdy, 3'b111);
            applyStimulus(vecs[i].data);
            expect_frame($sformatf("v%0d", i), vecs[i].sel, vecs[i].bits, vecs[i].nbits);
            if (vecs[i].chk_busy) begin
                cycle();
                checkOutput($sformatf("v%0d busy at stop end", i), bsy[0], 1);
                cycle();
                checkOutput($sformatf("v%0d busy after stop", i), bsy[0], 0);
            end
        end

        // Back-to-back frames with no idle bit between them.
        wait_idle();
        rx_q.delete();
        gap_q.delete();
        in_valid = 1'b1;
        in_data = 8'h55; checkOutput("b2b ready 0", rdy, 3'b111); cycle();
        in_data = 8'hAA; checkOutput("b2b ready 1", rdy, 3'b111); cycle();
        in_data = 8'hFF; checkOutput("b2b ready 2", rdy, 3'b111); cycle();
        in_valid = 1'b0;
        checkOutput("b2b ready after", rdy, 3'b111);
        wait_frames(3, 300);
        checkOutput("b2b data 0", rx_q[0], 8'h55);
        checkOutput("b2b data 1", rx_q[1], 8'hAA);
        checkOutput("b2b data 2", rx_q[2], 8'hFF);
        checkOutput("b2b gap 1", gap_q[1], 0);
        checkOutput("b2b gap 2", gap_q[2], 0);

        // Overflow with the baud stalled.
        wait_idle();
        baud_mode = 0;
        cycle();
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("ovf ready before write %0d", i), rdy, (i < 4) ? 3'b111 : 3'b000);
            in_data  = 8'h10 + 8'(i);
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        checkOutput("ovf count", dut0.u_fifo.count, 4);
        baud_mode = 1;
        wait_frames(4, 400);
        wait_idle();
        repeat (40) cycle();
        checkOutput("ovf frame total", rx_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf data %0d", i), rx_q[i], 8'h10 + 8'(i));
        end

        // Push and pop on the same edge, then refill while full.
        baud_mode = 0;
        cycle();
        rx_q.delete();
        applyStimulus(8'h01);
        applyStimulus(8'h02);
        applyStimulus(8'h03);
        checkOutput("pp count before", dut0.u_fifo.count, 3);
        baud_tick = 1'b1;
        in_data   = 8'h04;
        in_valid  = 1'b1;
        cycle();
        in_valid  = 1'b0;
        checkOutput("pp count unchanged", dut0.u_fifo.count, 3);
        checkOutput("pp frame started", txl[0], 0);
        applyStimulus(8'h05);
        checkOutput("pp count full", dut0.u_fifo.count, 4);
        checkOutput("pp ready when full", rdy, 3'b000);
        in_data   = 8'h06;
        in_valid  = 1'b1;
        baud_mode = 1;
        accepted  = 0;
        maxc      = 0;
        for (int n = 0; n < 300 && !accepted; n++) begin
            if (rdy[0]) accepted = 1;
            cycle();
            if (int'(dut0.u_fifo.count) > maxc) maxc = int'(dut0.u_fifo.count);
        end
        in_valid = 1'b0;
        checkOutput("pp held write accepted", accepted, 1);
        checkOutput("pp max count", maxc, 4);
        checkOutput("pp count after refill", dut0.u_fifo.count, 4);
        wait_frames(6, 700);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("pp data %0d", i), rx_q[i], 8'(i + 1));
        end

        // Baud tick held high every cycle.
        wait_idle();
        rx_q.delete();
        baud_mode = 2;
        baud_tick = 1'b1;
        applyStimulus(8'h5A);
        wait_frames(1, 100);
        checkOutput("cont tick data", rx_q[0], 8'h5A);
        baud_mode = 1;

        // Reset during data bit 3 of 0x3C, with a second byte queued behind it.
        wait_idle();
        rx_q.delete();
        applyStimulus(8'h3C);
        applyStimulus(8'h11);
        k = 0;
        while (txl[0] !== 1'b0 && k < 200) begin
            cycle();
            k++;
        end
        checkOutput("rst frame started", txl[0], 0);
        repeat (17) cycle();
        checkOutput("rst pre bit3", txl[0], 1);
        checkOutput("rst pre busy", bsy[0], 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst async tx", txl, 3'b111);
        checkOutput("rst async busy", bsy, 3'b000);
        checkOutput("rst async in_ready", rdy, 3'b111);
        checkOutput("rst count cleared", dut0.u_fifo.count, 0);
        repeat (3) cycle();
        rst    = 1'b0;
        tx_min = 1'b1;
        for (int n = 0; n < 80; n++) begin
            cycle();
            if (txl[0] !== 1'b1) tx_min = 1'b0;
        end
        checkOutput("rst no frame after release", tx_min, 1);
        checkOutput("rst nothing received", rx_q.size(), 0);
        checkOutput("rst busy stays low", bsy[0], 0);
        applyStimulus(8'hC3);
        expect_frame("post-rst", 0, {1'b0, 1'b1, 8'hC3, 1'b0}, 10);

        checkOutput("monitor stop bits", stop_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
